trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer and write-port arbiter in front of the machine-mode CSR file.
//  - Selects one event per trap: synchronous exception, MRET or enabled interrupt.
//  - Flushes and stalls the pipeline while it drains.
//  - Commits the trap state (or MRET mstatus) to the CSR file, then redirects fetch.
//  - Passes pipeline CSR writes through only while idle.
// PARAMETERS
//  DRAIN_MAX  15  max cycles spent in DRAIN waiting for PIPE_EMPTY_SP (>=1)
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  EXC_VALID_SM     in   1   sync exception raised by instruction in M stage
//  EXC_CAUSE_SM     in   5   exception code
//  EXC_TVAL_SM      in   32  exception tval
//  PC_SM            in   32  PC of instruction in M stage
//  INSTR_VALID_SM   in   1   valid instruction in M stage (interrupt take point)
//  MRET_SM          in   1   MRET in M stage
//  IRQ_EXT/IRQ_TIMER/IRQ_SOFT in 1 each  raw async interrupt levels
//  CSR_ENABLE_SM/CSR_WADR_SM[12]/CSR_WDATA_SM[32]  in  pipeline CSR write request
//  MSTATUS_RC/MTVEC_VALUE_RC/MIE_VALUE_RC/MEPC_SC  in 32  current CSR values
//  PIPE_EMPTY_SP    in   1   pipeline drained acknowledge
//  CSR_ENABLE_TC/CSR_WADR_TC[12]/CSR_WDATA_TC[32]  out  arbitrated CSR write port
//  EXCEPTION_TC     out  1   trap commit strobe to CSR file
//  MSTATUS_WDATA_TC/MIP_WDATA_TC/MEPC_WDATA_TC/MCAUSE_WDATA_TC/MTVAL_WDATA_TC  out 32
//  FLUSH_TC         out  1   kill in-flight instructions
//  STALL_TC         out  1   freeze fetch/decode
//  REDIRECT_VALID_TC out 1   one-cycle fetch redirect
//  REDIRECT_PC_TC   out  32  redirect target
// BEHAVIOUR
//  Reset
//  - Asynchronous; all outputs and state registers 0; FSM = IDLE.
//  - Reset mid-trap aborts the sequence; no partial CSR commit.
//  Interrupt pending
//  - Each IRQ line passes through a 2-flop synchronizer: pend = {ext->bit11, timer->bit7, soft->bit3}.
//  - MIP_WDATA_TC = pend, driven continuously.
//  IDLE event selection (evaluated each cycle)
//  - Priority: EXC_VALID_SM > MRET_SM > interrupt.
//  - Interrupt condition: INSTR_VALID_SM & MSTATUS_RC[3] & |(pend & MIE_VALUE_RC).
//  - Interrupt priority: ext(11) > soft(3) > timer(7).
//  - On an event, capture on that edge:
//    - kind
//    - cause = {irq, 26'b0, code}
//    - epc = PC_SM
//    - tval = exception ? EXC_TVAL_SM : 0
//    - MSTATUS_RC
//  - Same-cycle CSR_ENABLE_SM is dropped.
//  - Otherwise CSR_*_TC = CSR_*_SM combinationally.
//  FSM
//  - IDLE->DRAIN on event.
//  - DRAIN: FLUSH_TC=STALL_TC=1, CSR_ENABLE_TC=0, counter increments.
//    - Exit to COMMIT when PIPE_EMPTY_SP=1 (after >=1 DRAIN cycle) or count==DRAIN_MAX.
//  - COMMIT (1 cycle): STALL_TC=1.
//    - Trap: EXCEPTION_TC=1.
//      - MSTATUS_WDATA_TC = mst with MPIE(7)=MIE(3), MIE(3)=0, MPP(12:11)=2'b11.
//      - MEPC/MCAUSE/MTVAL_WDATA_TC = captured values.
//    - MRET: EXCEPTION_TC=0, CSR_ENABLE_TC=1, CSR_WADR_TC=12'h300.
//      - CSR_WDATA_TC = mst with MIE=MPIE, MPIE=1, MPP=2'b11.
//  - REDIRECT (1 cycle): REDIRECT_VALID_TC=1, STALL_TC=1 -> IDLE.
//    - Trap target base = {MTVEC_VALUE_RC[31:2],2'b00}.
//    - Vectored (mtvec[1:0]==1) interrupt target = base + 4*code; otherwise base.
//    - MRET target = MEPC_SC.
//  Event handling outside IDLE
//  - Events outside IDLE are ignored; pending interrupts are re-evaluated in IDLE.
//  - *_WDATA_TC outputs are 0 outside COMMIT, except MIP_WDATA_TC.
//  Latency: event edge N -> EXCEPTION_TC at N+1+d (d = DRAIN cycles) -> redirect at N+2+d.
// TESTING
//  1. Exception cause 2, PC_SM 0x100, tval 0x12345678, mtvec 0x80000000, mstatus 0x8, PIPE_EMPTY=1:
//     -> 1 DRAIN cycle; EXCEPTION_TC with MCAUSE 0x2, MEPC 0x100, MSTATUS 0x1880; redirect 0x80000000.
//  2. mtvec 0x80000001, mie 0x80, mstatus 0x8, IRQ_TIMER=1:
//     -> taken 2 cycles after assertion; MCAUSE 0x80000007, MTVAL 0, MIP bit7=1; redirect 0x8000001C.
//  3. MRET, mstatus 0x1880, mepc 0x204:
//     -> CSR_ENABLE_TC adr 0x300 data 0x1888; EXCEPTION_TC stays 0; redirect 0x204.
//  4. Same cycle: exception + enabled IRQ_EXT + pipeline CSR write:
//     -> exception cause committed; CSR write dropped; cause 0x8000000B trap follows after return to IDLE.
//  5. PIPE_EMPTY_SP held 0:
//     -> exactly 15 DRAIN cycles then COMMIT.
//     mstatus MIE=0 with pending IRQ -> no trap; CSR writes pass through.
//  6. reset pulsed during DRAIN:
//     -> FLUSH/STALL drop immediately; no EXCEPTION_TC; FSM in IDLE after release.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer and CSR write-port arbiter for the machine-mode CSR file.
// One event per trap (exception > MRET > interrupt) is drained, committed, then redirected.
module trap_ctrl #(
  parameter int DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXC_VALID_SM,
  input  logic [4:0]  EXC_CAUSE_SM,
  input  logic [31:0] EXC_TVAL_SM,
  input  logic [31:0] PC_SM,
  input  logic        INSTR_VALID_SM,
  input  logic        MRET_SM,
  input  logic        IRQ_EXT,
  input  logic        IRQ_TIMER,
  input  logic        IRQ_SOFT,
  input  logic        CSR_ENABLE_SM,
  input  logic [11:0] CSR_WADR_SM,
  input  logic [31:0] CSR_WDATA_SM,
  input  logic [31:0] MSTATUS_RC,
  input  logic [31:0] MTVEC_VALUE_RC,
  input  logic [31:0] MIE_VALUE_RC,
  input  logic [31:0] MEPC_SC,
  input  logic        PIPE_EMPTY_SP,
  output logic        CSR_ENABLE_TC,
  output logic [11:0] CSR_WADR_TC,
  output logic [31:0] CSR_WDATA_TC,
  output logic        EXCEPTION_TC,
  output logic [31:0] MSTATUS_WDATA_TC,
  output logic [31:0] MIP_WDATA_TC,
  output logic [31:0] MEPC_WDATA_TC,
  output logic [31:0] MCAUSE_WDATA_TC,
  output logic [31:0] MTVAL_WDATA_TC,
  output logic        FLUSH_TC,
  output logic        STALL_TC,
  output logic        REDIRECT_VALID_TC,
  output logic [31:0] REDIRECT_PC_TC,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       irq_meta, irq_sync;  // {ext, timer, soft}
  logic [31:0]      pend;
  logic [31:0]      irq_act;
  logic             irq_take;
  logic [4:0]       irq_code;
  logic             ev_exc, ev_mret, ev_irq, ev_any;
  logic [CNT_W-1:0] drain_cnt;
  logic             drain_done;

  logic             cap_mret;
  logic             cap_irq;
  logic [4:0]       cap_code;
  logic [31:0]      cap_epc;
  logic [31:0]      cap_tval;
  logic [31:0]      cap_mst;
  logic [31:0]      trap_mst, mret_mst;
  logic [31:0]      tvec_base, redirect_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= {IRQ_EXT, IRQ_TIMER, IRQ_SOFT};
      irq_sync <= irq_meta;
    end
  end

  always_comb begin
    pend     = '0;
    pend[11] = irq_sync[2];
    pend[7]  = irq_sync[1];
    pend[3]  = irq_sync[0];
  end

  assign MIP_WDATA_TC = pend;
  assign irq_act      = pend & MIE_VALUE_RC;
  assign irq_take     = INSTR_VALID_SM & MSTATUS_RC[3] & (|irq_act);

  // External beats software beats timer, unlike the bit order.
  always_comb begin
    irq_code = 5'd7;
    if (irq_act[11])     irq_code = 5'd11;
    else if (irq_act[3]) irq_code = 5'd3;
  end

  assign ev_exc  = EXC_VALID_SM;
  assign ev_mret = MRET_SM & ~EXC_VALID_SM;
  assign ev_irq  = irq_take & ~EXC_VALID_SM & ~MRET_SM;
  assign ev_any  = (state == ST_IDLE) & (ev_exc | ev_mret | ev_irq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_mret <= 1'b0;
      cap_irq  <= 1'b0;
      cap_code <= '0;
      cap_epc  <= '0;
      cap_tval <= '0;
      cap_mst  <= '0;
    end else if (ev_any) begin
      cap_mret <= ev_mret;
      cap_irq  <= ev_irq;
      cap_code <= ev_exc ? EXC_CAUSE_SM : (ev_irq ? irq_code : 5'd0);
      cap_epc  <= PC_SM;
      cap_tval <= ev_exc ? EXC_TVAL_SM : 32'd0;
      cap_mst  <= MSTATUS_RC;
    end
  end

  // Count is 1 in the first DRAIN cycle, so PIPE_EMPTY_SP can end the drain no earlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (ev_any) begin
      drain_cnt <= CNT_W'(1);
    end else if (state == ST_DRAIN && !drain_done) begin
      drain_cnt <= drain_cnt + CNT_W'(1);
    end
  end

  assign drain_done = PIPE_EMPTY_SP | (drain_cnt == CNT_W'(DRAIN_MAX));

  always_comb begin
    trap_mst        = cap_mst;
    trap_mst[7]     = cap_mst[3];
    trap_mst[3]     = 1'b0;
    trap_mst[12:11] = 2'b11;
    mret_mst        = cap_mst;
    mret_mst[3]     = cap_mst[7];
    mret_mst[7]     = 1'b1;
    mret_mst[12:11] = 2'b11;
  end

  assign tvec_base = {MTVEC_VALUE_RC[31:2], 2'b00};

  always_comb begin
    redirect_pc = tvec_base;
    if (cap_mret)
      redirect_pc = MEPC_SC;
    else if (cap_irq && MTVEC_VALUE_RC[1:0] == 2'b01)
      redirect_pc = tvec_base + {25'd0, cap_code, 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  assign state_dbg = state;

  always_comb begin
    state_nxt         = state;
    CSR_ENABLE_TC     = 1'b0;
    CSR_WADR_TC       = '0;
    CSR_WDATA_TC      = '0;
    EXCEPTION_TC      = 1'b0;
    MSTATUS_WDATA_TC  = '0;
    MEPC_WDATA_TC     = '0;
    MCAUSE_WDATA_TC   = '0;
    MTVAL_WDATA_TC    = '0;
    FLUSH_TC          = 1'b0;
    STALL_TC          = 1'b0;
    REDIRECT_VALID_TC = 1'b0;
    REDIRECT_PC_TC    = '0;
    case (state)
      ST_IDLE: begin
        // A pipeline CSR write coinciding with a trap event is dropped.
        CSR_ENABLE_TC = CSR_ENABLE_SM & ~ev_any;
        CSR_WADR_TC   = CSR_WADR_SM;
        CSR_WDATA_TC  = CSR_WDATA_SM;
        if (ev_any) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        FLUSH_TC = 1'b1;
        STALL_TC = 1'b1;
        if (drain_done) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        STALL_TC = 1'b1;
        if (cap_mret) begin
          CSR_ENABLE_TC = 1'b1;
          CSR_WADR_TC   = 12'h300;
          CSR_WDATA_TC  = mret_mst;
        end else begin
          EXCEPTION_TC     = 1'b1;
          MSTATUS_WDATA_TC = trap_mst;
          MEPC_WDATA_TC    = cap_epc;
          MCAUSE_WDATA_TC  = {cap_irq, 26'd0, cap_code};
          MTVAL_WDATA_TC   = cap_tval;
        end
        state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        STALL_TC          = 1'b1;
        REDIRECT_VALID_TC = 1'b1;
        REDIRECT_PC_TC    = redirect_pc;
        state_nxt         = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: commits and redirects are checked against expected queues.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXC_VALID_SM, INSTR_VALID_SM, MRET_SM;
  logic [4:0]  EXC_CAUSE_SM;
  logic [31:0] EXC_TVAL_SM, PC_SM;
  logic        IRQ_EXT, IRQ_TIMER, IRQ_SOFT;
  logic        CSR_ENABLE_SM;
  logic [11:0] CSR_WADR_SM;
  logic [31:0] CSR_WDATA_SM;
  logic [31:0] MSTATUS_RC, MTVEC_VALUE_RC, MIE_VALUE_RC, MEPC_SC;
  logic        PIPE_EMPTY_SP;
  logic        CSR_ENABLE_TC;
  logic [11:0] CSR_WADR_TC;
  logic [31:0] CSR_WDATA_TC;
  logic        EXCEPTION_TC;
  logic [31:0] MSTATUS_WDATA_TC, MIP_WDATA_TC, MEPC_WDATA_TC, MCAUSE_WDATA_TC, MTVAL_WDATA_TC;
  logic        FLUSH_TC, STALL_TC, REDIRECT_VALID_TC;
  logic [31:0] REDIRECT_PC_TC;
  logic [1:0]  state_dbg;

  localparam logic [1:0] S_IDLE = 2'd0, S_DRAIN = 2'd1, S_COMMIT = 2'd2, S_REDIR = 2'd3;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [127:0] exp_trap_q[$];   // {mstatus, mepc, mcause, mtval}
  logic [43:0]  exp_mret_q[$];   // {adr, data}
  logic [31:0]  exp_redir_q[$];
  logic [127:0] e_trap;
  logic [43:0]  e_mret;
  logic [31:0]  e_redir;

  trap_ctrl #(.DRAIN_MAX(15)) dut (
    .clk(clk), .reset(reset),
    .EXC_VALID_SM(EXC_VALID_SM), .EXC_CAUSE_SM(EXC_CAUSE_SM), .EXC_TVAL_SM(EXC_TVAL_SM),
    .PC_SM(PC_SM), .INSTR_VALID_SM(INSTR_VALID_SM), .MRET_SM(MRET_SM),
    .IRQ_EXT(IRQ_EXT), .IRQ_TIMER(IRQ_TIMER), .IRQ_SOFT(IRQ_SOFT),
    .CSR_ENABLE_SM(CSR_ENABLE_SM), .CSR_WADR_SM(CSR_WADR_SM), .CSR_WDATA_SM(CSR_WDATA_SM),
    .MSTATUS_RC(MSTATUS_RC), .MTVEC_VALUE_RC(MTVEC_VALUE_RC), .MIE_VALUE_RC(MIE_VALUE_RC),
    .MEPC_SC(MEPC_SC), .PIPE_EMPTY_SP(PIPE_EMPTY_SP),
    .CSR_ENABLE_TC(CSR_ENABLE_TC), .CSR_WADR_TC(CSR_WADR_TC), .CSR_WDATA_TC(CSR_WDATA_TC),
    .EXCEPTION_TC(EXCEPTION_TC), .MSTATUS_WDATA_TC(MSTATUS_WDATA_TC), .MIP_WDATA_TC(MIP_WDATA_TC),
    .MEPC_WDATA_TC(MEPC_WDATA_TC), .MCAUSE_WDATA_TC(MCAUSE_WDATA_TC), .MTVAL_WDATA_TC(MTVAL_WDATA_TC),
    .FLUSH_TC(FLUSH_TC), .STALL_TC(STALL_TC), .REDIRECT_VALID_TC(REDIRECT_VALID_TC),
    .REDIRECT_PC_TC(REDIRECT_PC_TC), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    EXC_VALID_SM   = 1'b0;
    INSTR_VALID_SM = 1'b0;
    MRET_SM        = 1'b0;
    CSR_ENABLE_SM  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (state_dbg !== S_IDLE && n < 40) begin
      tick();
      n++;
    end
    check(tag, 128'(state_dbg), 128'(S_IDLE));
  endtask

  // Scoreboard: every commit/redirect the DUT emits must match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (EXCEPTION_TC) begin
        if (exp_trap_q.size() == 0) check("trap_unexpected", 128'(EXCEPTION_TC), 128'(0));
        else begin
          e_trap = exp_trap_q.pop_front();
          check("trap_commit", {MSTATUS_WDATA_TC, MEPC_WDATA_TC, MCAUSE_WDATA_TC, MTVAL_WDATA_TC}, e_trap);
        end
      end
      if (CSR_ENABLE_TC && STALL_TC) begin
        if (exp_mret_q.size() == 0) check("mret_unexpected", 128'(CSR_ENABLE_TC), 128'(0));
        else begin
          e_mret = exp_mret_q.pop_front();
          check("mret_commit", 128'({CSR_WADR_TC, CSR_WDATA_TC}), 128'(e_mret));
        end
      end
      if (REDIRECT_VALID_TC) begin
        if (exp_redir_q.size() == 0) check("redirect_unexpected", 128'(REDIRECT_VALID_TC), 128'(0));
        else begin
          e_redir = exp_redir_q.pop_front();
          check("redirect_pc", 128'(REDIRECT_PC_TC), 128'(e_redir));
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    clear_events();
    EXC_CAUSE_SM = '0; EXC_TVAL_SM = '0; PC_SM = '0;
    IRQ_EXT = 1'b0; IRQ_TIMER = 1'b0; IRQ_SOFT = 1'b0;
    CSR_WADR_SM = '0; CSR_WDATA_SM = '0;
    MSTATUS_RC = '0; MTVEC_VALUE_RC = '0; MIE_VALUE_RC = '0; MEPC_SC = '0;
    PIPE_EMPTY_SP = 1'b0;
    tick(); tick();
    check("rst_state", 128'(state_dbg), 128'(S_IDLE));
    check("rst_flush_stall", 128'({FLUSH_TC, STALL_TC}), 128'(0));
    check("rst_exc_redir", 128'({EXCEPTION_TC, REDIRECT_VALID_TC, CSR_ENABLE_TC}), 128'(0));
    check("rst_wdata", {MSTATUS_WDATA_TC, MIP_WDATA_TC, MCAUSE_WDATA_TC, REDIRECT_PC_TC}, 128'(0));
    reset = 1'b0;
    tick();

    // 1: synchronous exception, single drain cycle
    MTVEC_VALUE_RC = 32'h8000_0000; MSTATUS_RC = 32'h8; PIPE_EMPTY_SP = 1'b1;
    EXC_VALID_SM = 1'b1; EXC_CAUSE_SM = 5'd2; PC_SM = 32'h100; EXC_TVAL_SM = 32'h1234_5678;
    INSTR_VALID_SM = 1'b1;
    exp_trap_q.push_back({32'h1880, 32'h100, 32'h2, 32'h1234_5678});
    exp_redir_q.push_back(32'h8000_0000);
    tick();
    clear_events();
    check("t1_drain", 128'({state_dbg, FLUSH_TC, STALL_TC}), 128'({S_DRAIN, 2'b11}));
    tick();
    check("t1_commit", 128'({state_dbg, EXCEPTION_TC, STALL_TC, FLUSH_TC}), 128'({S_COMMIT, 3'b110}));
    tick();
    check("t1_redirect", 128'({state_dbg, REDIRECT_VALID_TC}), 128'({S_REDIR, 1'b1}));
    tick();
    check("t1_idle", 128'({state_dbg, STALL_TC}), 128'({S_IDLE, 1'b0}));

    // 2: vectored timer interrupt through the synchronizer
    MTVEC_VALUE_RC = 32'h8000_0001; MIE_VALUE_RC = 32'h80; MSTATUS_RC = 32'h8;
    INSTR_VALID_SM = 1'b1; PC_SM = 32'h300; IRQ_TIMER = 1'b1;
    exp_trap_q.push_back({32'h1880, 32'h300, 32'h8000_0007, 32'h0});
    exp_redir_q.push_back(32'h8000_001C);
    #1 check("t2_mip_pre", 128'(MIP_WDATA_TC), 128'(0));
    tick();
    check("t2_mip_meta", 128'({MIP_WDATA_TC, state_dbg}), 128'({32'h0, S_IDLE}));
    tick();
    check("t2_mip_sync", 128'({MIP_WDATA_TC, state_dbg}), 128'({32'h80, S_IDLE}));
    tick();
    check("t2_taken", 128'(state_dbg), 128'(S_DRAIN));
    IRQ_TIMER = 1'b0; clear_events(); MIE_VALUE_RC = '0;
    wait_idle("t2_return");

    // 3: MRET restores mstatus through the CSR port
    MSTATUS_RC = 32'h1880; MEPC_SC = 32'h204; MRET_SM = 1'b1; INSTR_VALID_SM = 1'b1;
    exp_mret_q.push_back({12'h300, 32'h1888});
    exp_redir_q.push_back(32'h204);
    tick();
    clear_events();
    tick();
    check("t3_commit", 128'({state_dbg, EXCEPTION_TC, CSR_ENABLE_TC}), 128'({S_COMMIT, 2'b01}));
    wait_idle("t3_return");

    // 4: exception wins over external IRQ and drops the same-cycle CSR write
    MSTATUS_RC = 32'h8; MIE_VALUE_RC = 32'h800; MTVEC_VALUE_RC = 32'h8000_0000; IRQ_EXT = 1'b1;
    tick(); tick();
    EXC_VALID_SM = 1'b1; EXC_CAUSE_SM = 5'd5; PC_SM = 32'h400; EXC_TVAL_SM = 32'hDEAD;
    INSTR_VALID_SM = 1'b1;
    CSR_ENABLE_SM = 1'b1; CSR_WADR_SM = 12'h340; CSR_WDATA_SM = 32'hAAAA;
    exp_trap_q.push_back({32'h1880, 32'h400, 32'h5, 32'hDEAD});
    exp_redir_q.push_back(32'h8000_0000);
    exp_trap_q.push_back({32'h1880, 32'h404, 32'h8000_000B, 32'h0});
    exp_redir_q.push_back(32'h8000_0000);
    #1 check("t4_csr_dropped", 128'(CSR_ENABLE_TC), 128'(0));
    tick();
    EXC_VALID_SM = 1'b0; CSR_ENABLE_SM = 1'b0; PC_SM = 32'h404;
    wait_idle("t4_first_return");
    tick();
    check("t4_irq_follows", 128'(state_dbg), 128'(S_DRAIN));
    IRQ_EXT = 1'b0; clear_events();
    wait_idle("t4_second_return");

    // 5a: pipeline never empties, drain times out
    PIPE_EMPTY_SP = 1'b0; MIE_VALUE_RC = '0;
    EXC_VALID_SM = 1'b1; EXC_CAUSE_SM = 5'd1; PC_SM = 32'h500; EXC_TVAL_SM = 32'h0;
    INSTR_VALID_SM = 1'b1;
    exp_trap_q.push_back({32'h1880, 32'h500, 32'h1, 32'h0});
    exp_redir_q.push_back(32'h8000_0000);
    tick();
    clear_events();
    n = 0;
    while (state_dbg === S_DRAIN && n < 40) begin
      n++;
      tick();
    end
    check("t5_drain_cycles", 128'(n), 128'(15));
    check("t5_commit", 128'({state_dbg, EXCEPTION_TC}), 128'({S_COMMIT, 1'b1}));
    wait_idle("t5_return");

    // 5b: interrupts globally disabled, CSR writes pass through
    PIPE_EMPTY_SP = 1'b1; MSTATUS_RC = 32'h0; MIE_VALUE_RC = 32'h800; IRQ_EXT = 1'b1;
    INSTR_VALID_SM = 1'b1;
    CSR_ENABLE_SM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      CSR_WADR_SM = 12'($urandom_range(12'h340, 12'h344));
      CSR_WDATA_SM = $urandom;
      tick();
      check("t5_no_trap", 128'(state_dbg), 128'(S_IDLE));
      check("t5_passthru", 128'({CSR_ENABLE_TC, CSR_WADR_TC, CSR_WDATA_TC}),
            128'({1'b1, CSR_WADR_SM, CSR_WDATA_SM}));
    end
    check("t5_mip", 128'(MIP_WDATA_TC), 128'(32'h800));
    IRQ_EXT = 1'b0; clear_events(); MIE_VALUE_RC = '0;
    tick(); tick(); tick();

    // 6: reset in the middle of DRAIN aborts the trap
    MSTATUS_RC = 32'h8; PIPE_EMPTY_SP = 1'b0;
    EXC_VALID_SM = 1'b1; EXC_CAUSE_SM = 5'd4; PC_SM = 32'h600; INSTR_VALID_SM = 1'b1;
    tick();
    clear_events();
    check("t6_drain", 128'({state_dbg, FLUSH_TC}), 128'({S_DRAIN, 1'b1}));
    tick();
    #2 reset = 1'b1;
    #1 check("t6_async_drop", 128'({FLUSH_TC, STALL_TC, state_dbg}), 128'({2'b00, S_IDLE}));
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle_after", 128'({state_dbg, EXCEPTION_TC, STALL_TC}), 128'({S_IDLE, 2'b00}));
    end
    check("t6_mip", 128'(MIP_WDATA_TC), 128'(0));

    check("trap_q_drained", 128'(exp_trap_q.size()), 128'(0));
    check("mret_q_drained", 128'(exp_mret_q.size()), 128'(0));
    check("redir_q_drained", 128'(exp_redir_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
